detector_jogada: RTL and testbench

Button-conditioning front end that sits directly upstream of jogo_desafio_memoria's datapath and control unit. It synchronises and debounces the raw `botoes` inputs and accepts one press per physical actuation. For each accepted press it emits a single-cycle `jogada_feita` pulse with a registered `jogada` code. This replaces direct level sampling of `botoes`, so one 100 ms press yields exactly one play.

---
 rtl/detector_jogada_pkg.sv | 17 +
 rtl/detector_jogada_sincronizador_botoes.sv | 27 ++
 rtl/detector_jogada.sv | 109 ++++++++++
 tb/tb_detector_jogada.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/detector_jogada_pkg.sv
// Shared FSM encodings and defaults for the button play detector.
// The control unit decodes db_estado with these same constants.
package detector_jogada_pkg;

    localparam logic [2:0] INICIAL       = 3'b000;
    localparam logic [2:0] LIVRE         = 3'b001;
    localparam logic [2:0] FILTRANDO     = 3'b010;
    localparam logic [2:0] REGISTRA      = 3'b011;
    localparam logic [2:0] ESPERA_SOLTAR = 3'b100;

    localparam int DEBOUNCE_PADRAO = 20;

    function automatic logic mais_de_um_bit(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/detector_jogada_sincronizador_botoes.sv
// Two-flop synchroniser for the raw asynchronous push-buttons.
// Second stage feeds the debounce FSM.
module sincronizador_botoes #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] botoes,
    output logic [N-1:0] botoes_s
);

    logic [N-1:0] estagio1_q;
    logic [N-1:0] estagio2_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estagio1_q <= '0;
            estagio2_q <= '0;
        end else begin
            estagio1_q <= botoes;
            estagio2_q <= estagio1_q;
        end
    end

    assign botoes_s = estagio2_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounced one-pulse-per-press detector feeding the memory game.
// Accepts a stable pattern, emits a single-cycle jogada_feita pulse.
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter int CNT_W           = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] jogada,
    output logic                jogada_feita,
    output logic                multipla,
    output logic [2:0]          db_estado
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] botoes_s;
    logic [N_BOTOES-1:0] botoes_ant_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          estado_q, estado_d;
    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic                multipla_q, multipla_d;
    logic                mudou;
    logic                estavel;
    logic                entra;
    logic                limpa;

    sincronizador_botoes #(.N(N_BOTOES)) u_sinc (
        .clock    (clock),
        .reset    (reset),
        .botoes   (botoes),
        .botoes_s (botoes_s)
    );

    assign mudou   = botoes_s != botoes_ant_q;
    assign estavel = !mudou && (cnt_q == CNT_MAX);

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL: estado_d = ESPERA_SOLTAR;
            LIVRE: begin
                if (botoes_s != '0) estado_d = FILTRANDO;
            end
            FILTRANDO: begin
                if (botoes_s == '0)
                    estado_d = LIVRE;
                else if (estavel)
                    estado_d = habilita ? REGISTRA : ESPERA_SOLTAR;
            end
            REGISTRA: estado_d = ESPERA_SOLTAR;
            ESPERA_SOLTAR: begin
                if (botoes_s == '0 && estavel) estado_d = LIVRE;
            end
            default: estado_d = INICIAL;
        endcase
    end

    // Counter restarts on every entry into a filtering state.
    assign entra = (estado_d != estado_q) &&
                   (estado_d == FILTRANDO || estado_d == ESPERA_SOLTAR);
    assign limpa = entra || mudou ||
                   (estado_q == ESPERA_SOLTAR && botoes_s != '0);

    always_comb begin
        if (limpa)
            cnt_d = '0;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        jogada_d   = jogada_q;
        multipla_d = multipla_q;
        if (estado_d == REGISTRA && estado_q != REGISTRA) begin
            jogada_d   = botoes_s;
            multipla_d = mais_de_um_bit(32'(botoes_s));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q     <= INICIAL;
            cnt_q        <= '0;
            botoes_ant_q <= '0;
            jogada_q     <= '0;
            multipla_q   <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            botoes_ant_q <= botoes_s;
            jogada_q     <= jogada_d;
            multipla_q   <= multipla_d;
        end
    end

    assign jogada       = jogada_q;
    assign multipla     = multipla_q;
    assign jogada_feita = (estado_q == REGISTRA);
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada: press, bounce, glitch, multi,
// disabled and reset scenarios with hand-computed pulse timing.
module tb_detector_jogada;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] botoes;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       multipla;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int pulse_cyc = -1;
    int p0;
    int t0;

    detector_jogada dut (
        .clock        (clock),
        .reset        (reset),
        .habilita     (habilita),
        .botoes       (botoes),
        .jogada       (jogada),
        .jogada_feita (jogada_feita),
        .multipla     (multipla),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (jogada_feita === 1'b1) begin
            pulses++;
            pulse_cyc = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        habilita = 1'b1;
        botoes   = 4'b0000;
        run(3);
        check("rst_jogada", 32'(jogada), 0);
        check("rst_multipla", 32'(multipla), 0);
        check("rst_feita", 32'(jogada_feita), 0);
        check("rst_estado", 32'(db_estado), 0);
        reset = 1'b1;
        run(30);
        check("idle_livre", 32'(db_estado), 1);

        // Clean press
        p0 = pulses; t0 = cyc;
        botoes = 4'b0001;
        run(100);
        check("clean_count", pulses - p0, 1);
        check("clean_time", pulse_cyc, t0 + 23);
        check("clean_jogada", 32'(jogada), 1);
        check("clean_multipla", 32'(multipla), 0);
        botoes = 4'b0000;
        run(40);
        check("clean_release_count", pulses - p0, 1);
        check("clean_release_livre", 32'(db_estado), 1);

        // Bounce
        p0 = pulses;
        repeat (2) begin
            botoes = 4'b0001; run(3);
            botoes = 4'b0000; run(3);
        end
        botoes = 4'b0001; t0 = cyc;
        run(100);
        check("bounce_count", pulses - p0, 1);
        check("bounce_time", pulse_cyc, t0 + 23);
        botoes = 4'b0000;
        run(40);

        // Glitch
        p0 = pulses;
        botoes = 4'b0100; run(10);
        botoes = 4'b0000; run(5);
        check("glitch_count", pulses - p0, 0);
        check("glitch_livre", 32'(db_estado), 1);
        t0 = cyc;
        botoes = 4'b0100; run(100);
        check("glitch_press_count", pulses - p0, 1);
        check("glitch_press_time", pulse_cyc, t0 + 23);
        check("glitch_press_jogada", 32'(jogada), 4);
        botoes = 4'b0000;
        run(40);

        // Multi-press
        p0 = pulses;
        botoes = 4'b1111; run(100);
        check("multi_count", pulses - p0, 1);
        check("multi_jogada", 32'(jogada), 15);
        check("multi_multipla", 32'(multipla), 1);
        botoes = 4'b0000;
        run(40);

        // Disabled
        p0 = pulses;
        habilita = 1'b0;
        botoes = 4'b0010; run(100);
        check("dis_count", pulses - p0, 0);
        check("dis_estado", 32'(db_estado), 4);
        check("dis_jogada_hold", 32'(jogada), 15);
        habilita = 1'b1; run(30);
        check("dis_enable_held", pulses - p0, 0);
        botoes = 4'b0000; run(40);
        check("dis_release_count", pulses - p0, 0);
        check("dis_release_livre", 32'(db_estado), 1);
        t0 = cyc;
        botoes = 4'b0010; run(60);
        check("dis_repress_count", pulses - p0, 1);
        check("dis_repress_time", pulse_cyc, t0 + 23);
        check("dis_repress_jogada", 32'(jogada), 2);
        check("dis_repress_multipla", 32'(multipla), 0);
        botoes = 4'b0000;
        run(40);

        // Reset mid-filter, button held through reset
        p0 = pulses;
        botoes = 4'b1000; run(10);
        check("rst_pre_filtrando", 32'(db_estado), 2);
        reset = 1'b0; run(1);
        check("rst_mid_estado", 32'(db_estado), 0);
        check("rst_mid_jogada", 32'(jogada), 0);
        check("rst_mid_multipla", 32'(multipla), 0);
        check("rst_mid_feita", 32'(jogada_feita), 0);
        run(1);
        check("rst_mid_estado2", 32'(db_estado), 0);
        reset = 1'b1;
        run(60);
        check("held_count", pulses - p0, 0);
        check("held_estado", 32'(db_estado), 4);
        botoes = 4'b0000; run(40);
        check("held_release_count", pulses - p0, 0);
        check("held_release_livre", 32'(db_estado), 1);
        t0 = cyc;
        botoes = 4'b1000; run(60);
        check("held_repress_count", pulses - p0, 1);
        check("held_repress_time", pulse_cyc, t0 + 23);
        check("held_repress_jogada", 32'(jogada), 8);
        botoes = 4'b0000;
        run(40);
        check("final_count", pulses - p0, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
